lock_attempt_controller: RTL and testbench

Sequences access attempts for the password-based lock. Two requesters share a single password-compare resource: requester 0 is the keypad and requester 1 is the remote link. Grants are round-robin. The block counts consecutive failures, holds the door open for a fixed time on success, and enters a timed lockout with alarm after MAX_FAIL consecutive failures.

---
 rtl/lock_pkg.sv | 19 +
 rtl/lock_rr_arbiter2.sv | 27 ++
 rtl/lock_attempt_controller.sv | 121 ++++++++++++
 tb/tb_lock_attempt_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the password lock attempt controller.
package lock_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Requester indices into req/gnt/done
  localparam int REQ_KEYPAD = 0;
  localparam int REQ_REMOTE = 1;

  // Default code width
  localparam int DEF_PASS_W = 14;

endpackage

// File: rtl/lock_rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational; the pointer moves
// to the other requester after every grant so the loser goes first next time.
module lock_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic rr_ptr;
  logic win;

  // Pick the pointed-to requester if it is asking, otherwise the other one
  always_comb begin
    win = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    gnt = 2'b00;
    if (enable && (req != 2'b00)) gnt[win] = 1'b1;
  end

  // Pointer flips to the non-winner whenever a grant is issued
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        rr_ptr <= 1'b0;
    else if (enable && (req != 2'b00)) rr_ptr <= ~win;
  end

endmodule

// File: rtl/lock_attempt_controller.sv
// Attempt sequencer for the password lock: arbitrates keypad/remote
// requests, checks one code per grant, holds the door open on success and
// enters a timed alarm lockout after MAX_FAIL consecutive failures.
module lock_attempt_controller
  import lock_pkg::*;
#(
  parameter int PASS_W      = DEF_PASS_W,
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PASS_W-1:0] ref_code,
  input  logic [1:0]        req,
  input  logic [PASS_W-1:0] code0,
  input  logic [PASS_W-1:0] code1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              ok,
  output logic              access,
  output logic              alarm,
  output logic              locked,
  output logic [3:0]        fail_cnt
);

  // Shared OPEN/LOCKOUT timer sized for the longer of the two
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t            state;
  logic [TW-1:0]     timer;
  logic [PASS_W-1:0] code_q;
  logic              owner;
  logic [1:0]        arb_gnt;
  logic [4:0]        fail_inc;
  logic              match;

  lock_rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .enable (state == IDLE),
    .gnt    (arb_gnt)
  );

  // Widened so the next-count compare cannot wrap near 15
  assign fail_inc = {1'b0, fail_cnt} + 5'd1;
  // ref_code is only looked at here, i.e. in the CHECK cycle
  assign match    = (code_q == ref_code);

  // Main FSM with shared timer; every output is a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      code_q   <= '0;
      owner    <= 1'b0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      ok       <= 1'b0;
      access   <= 1'b0;
      alarm    <= 1'b0;
      locked   <= 1'b0;
      fail_cnt <= 4'd0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      ok   <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            gnt    <= arb_gnt;
            owner  <= arb_gnt[REQ_REMOTE];
            code_q <= arb_gnt[REQ_REMOTE] ? code1 : code0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          done[owner] <= 1'b1;
          ok          <= match;
          if (match) begin
            fail_cnt <= 4'd0;
            access   <= 1'b1;
            timer    <= TW'(OPEN_CYCLES);
            state    <= OPEN;
          end else if (fail_inc >= 5'(MAX_FAIL)) begin
            fail_cnt <= 4'(MAX_FAIL);
            alarm    <= 1'b1;
            locked   <= 1'b1;
            timer    <= TW'(LOCK_CYCLES);
            state    <= LOCKOUT;
          end else begin
            fail_cnt <= fail_inc[3:0];
            state    <= IDLE;
          end
        end
        OPEN: begin
          if (timer == TW'(1)) begin
            access <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOCKOUT: begin
          if (timer == TW'(1)) begin
            alarm    <= 1'b0;
            locked   <= 1'b0;
            fail_cnt <= 4'd0;
            state    <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Directed bench for lock_attempt_controller (default parameters:
// MAX_FAIL=3, OPEN_CYCLES=8, LOCK_CYCLES=16).
module tb_lock_attempt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] ref_code, code0, code1;
  logic [1:0]  req, gnt, done;
  logic        ok, access, alarm, locked;
  logic [3:0]  fail_cnt;

  int checks   = 0;
  int failures = 0;

  lock_attempt_controller dut (
    .clk(clk), .reset(reset), .ref_code(ref_code), .req(req),
    .code0(code0), .code1(code1), .gnt(gnt), .done(done), .ok(ok),
    .access(access), .alarm(alarm), .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; code0 = '0; code1 = '0; ref_code = 14'd1234;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00; code0 = '0; code1 = '0; ref_code = 14'd1234;
    #3;
    checks++;
    if ({gnt, done, ok, access, alarm, locked, fail_cnt} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {gnt, done, ok, access, alarm, locked, fail_cnt});
    end
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_open();
    do_reset();
    req = 2'b01; code0 = 14'd1234;
    tick();
    checks++;
    if (gnt !== 2'b01 || done !== 2'b00) begin
      failures++; $display("FAIL open_gnt gnt=%b done=%b exp gnt=01 done=00", gnt, done);
    end
    tick();
    checks++;
    if (done !== 2'b01 || ok !== 1'b1 || access !== 1'b1 || fail_cnt !== 4'd0) begin
      failures++; $display("FAIL open_done done=%b ok=%b access=%b fc=%0d exp 01/1/1/0", done, ok, access, fail_cnt);
    end
    req = 2'b00;
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (access !== 1'b1 || gnt !== 2'b00) begin
        failures++; $display("FAIL open_hold cyc=%0d access=%b gnt=%b exp 1/00", i + 1, access, gnt);
      end
    end
    tick();
    checks++;
    if (access !== 1'b0) begin
      failures++; $display("FAIL open_end access=%b exp 0", access);
    end
  endtask

  task automatic test_fail_lockout();
    do_reset();
    req = 2'b10; code1 = 14'd1111;
    for (int a = 1; a <= 3; a++) begin
      tick();
      checks++;
      if (gnt !== 2'b10) begin
        failures++; $display("FAIL lk_gnt a=%0d gnt=%b exp 10", a, gnt);
      end
      tick();
      checks++;
      if (done !== 2'b10 || ok !== 1'b0 || fail_cnt !== 4'(a) || locked !== (a == 3) || alarm !== (a == 3)) begin
        failures++;
        $display("FAIL lk_done a=%0d done=%b ok=%b fc=%0d locked=%b alarm=%b exp 10/0/%0d/%0d", a, done, ok, fail_cnt, locked, alarm, a, a == 3);
      end
    end
    req = 2'b01; code0 = 14'd1234;
    for (int i = 2; i <= 16; i++) begin
      tick();
      checks++;
      if (locked !== 1'b1 || alarm !== 1'b1 || gnt !== 2'b00 || done !== 2'b00) begin
        failures++; $display("FAIL lk_hold cyc=%0d locked=%b alarm=%b gnt=%b done=%b", i, locked, alarm, gnt, done);
      end
    end
    tick();
    checks++;
    if (locked !== 1'b0 || alarm !== 1'b0 || fail_cnt !== 4'd0) begin
      failures++; $display("FAIL lk_exit locked=%b alarm=%b fc=%0d exp 0/0/0", locked, alarm, fail_cnt);
    end
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      failures++; $display("FAIL lk_after_gnt gnt=%b exp 01", gnt);
    end
    req = 2'b00;
    tick();
    checks++;
    if (done !== 2'b01 || ok !== 1'b1) begin
      failures++; $display("FAIL lk_after_done done=%b ok=%b exp 01/1", done, ok);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    do_reset();
    req = 2'b11; code0 = 14'd1; code1 = 14'd2;
    for (int a = 0; a < 3; a++) begin
      tick();
      checks++;
      if (gnt !== exp_g[a]) begin
        failures++; $display("FAIL rr_gnt a=%0d gnt=%b exp %b", a, gnt, exp_g[a]);
      end
      tick();
      checks++;
      if (done !== exp_g[a] || ok !== 1'b0 || locked !== (a == 2)) begin
        failures++; $display("FAIL rr_done a=%0d done=%b ok=%b locked=%b exp %b/0/%0d", a, done, ok, locked, exp_g[a], a == 2);
      end
    end
    req = 2'b00;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (locked !== 1'b0) begin
      failures++; $display("FAIL rr_unlock locked=%b exp 0", locked);
    end
  endtask

  task automatic test_fail_then_success();
    do_reset();
    req = 2'b10; code1 = 14'd1111;
    tick(); tick();
    tick(); tick();
    checks++;
    if (fail_cnt !== 4'd2) begin
      failures++; $display("FAIL fs_two fc=%0d exp 2", fail_cnt);
    end
    code1 = 14'd1234;
    tick(); tick();
    checks++;
    if (ok !== 1'b1 || fail_cnt !== 4'd0 || access !== 1'b1) begin
      failures++; $display("FAIL fs_ok ok=%b fc=%0d access=%b exp 1/0/1", ok, fail_cnt, access);
    end
    req = 2'b00; code1 = 14'd1111;
    for (int i = 0; i < 8; i++) tick();
    req = 2'b10;
    for (int a = 1; a <= 3; a++) begin
      tick(); tick();
      checks++;
      if (done !== 2'b10 || fail_cnt !== 4'(a) || locked !== (a == 3)) begin
        failures++; $display("FAIL fs_relock a=%0d done=%b fc=%0d locked=%b exp 10/%0d/%0d", a, done, fail_cnt, locked, a, a == 3);
      end
    end
    req = 2'b00;
    for (int i = 0; i < 16; i++) tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01; code0 = 14'd1234;
    tick(); tick();
    req = 2'b00;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (access !== 1'b0 || fail_cnt !== 4'd0) begin
      failures++; $display("FAIL rm_open access=%b fc=%0d exp 0/0", access, fail_cnt);
    end
    tick();
    reset = 1'b0;
    req = 2'b11; code0 = 14'd1; code1 = 14'd2;
    tick();
    checks++;
    if (gnt !== 2'b01) begin
      failures++; $display("FAIL rm_ptr gnt=%b exp 01", gnt);
    end
    req = 2'b10;
    tick();
    checks++;
    if (done !== 2'b01 || fail_cnt !== 4'd1) begin
      failures++; $display("FAIL rm_fail done=%b fc=%0d exp 01/1", done, fail_cnt);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (locked !== 1'b1 || fail_cnt !== 4'd3) begin
      failures++; $display("FAIL rm_lock locked=%b fc=%0d exp 1/3", locked, fail_cnt);
    end
    req = 2'b00;
    tick(); tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (alarm !== 1'b0 || locked !== 1'b0 || fail_cnt !== 4'd0) begin
      failures++; $display("FAIL rm_lockout alarm=%b locked=%b fc=%0d exp 0/0/0", alarm, locked, fail_cnt);
    end
    tick();
    reset = 1'b0;
    req = 2'b10; code1 = 14'd1234;
    tick();
    checks++;
    if (gnt !== 2'b10) begin
      failures++; $display("FAIL rm_regnt gnt=%b exp 10", gnt);
    end
    req = 2'b00;
    tick();
    checks++;
    if (done !== 2'b10 || ok !== 1'b1) begin
      failures++; $display("FAIL rm_redone done=%b ok=%b exp 10/1", done, ok);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_ref_change();
    do_reset();
    req = 2'b01; code0 = 14'd4321;
    tick();
    ref_code = 14'd4321;
    tick();
    checks++;
    if (done !== 2'b01 || ok !== 1'b1) begin
      failures++; $display("FAIL ref_change done=%b ok=%b exp 01/1", done, ok);
    end
    req = 2'b00;
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    test_reset();
    test_open();
    test_fail_lockout();
    test_round_robin();
    test_fail_then_success();
    test_reset_mid();
    test_ref_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
